// File: rtl/gcd_pkg.sv
// Shared types and constants for the round-robin GCD scheduler and its core.
// Optional perf counters in the top are enabled by GCD_SCHED_PERF_EN.
package gcd_pkg;

    localparam int GCD_W    = 16;
    localparam int GCD_NREQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gcd_state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int gcd_id_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gcd_rr_sched_if.sv
// Request/result handshake bundle between requesters, the consumer and the scheduler.
interface gcd_rr_sched_if
    import gcd_pkg::*;
#(
    parameter int NREQ = GCD_NREQ,
    parameter int W    = GCD_W
);
    localparam int IDW = gcd_id_w(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic [IDW-1:0]    res_id;
    logic [W-1:0]      res_gcd;
    logic              res_ready;
    logic              busy;

    modport master (
        output req_valid, req_x, req_y, res_ready,
        input  req_ready, res_valid, res_id, res_gcd, busy
    );

    modport slave (
        input  req_valid, req_x, req_y, res_ready,
        output req_ready, res_valid, res_id, res_gcd, busy
    );

endinterface

// File: rtl/gcd_core.sv
// Subtractive GCD datapath: one compare/subtract per enabled clock on the latched pair.
module gcd_core
    import gcd_pkg::*;
#(
    parameter int W = GCD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] y_in,
    input  logic         step,
    output logic         done,
    output logic [W-1:0] result
);

    logic [W-1:0] x_q, x_d;
    logic [W-1:0] y_q, y_d;
    logic         zero_s;

    assign zero_s = (x_q == {W{1'b0}}) || (y_q == {W{1'b0}});
    assign done   = zero_s || (x_q == y_q);
    assign result = zero_s ? {W{1'b0}} : x_q;

    // Larger operand is always the minuend, so the subtraction never wraps.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (load) begin
            x_d = x_in;
            y_d = y_in;
        end else if (step && !done) begin
            if (x_q > y_q) begin
                x_d = x_q - y_q;
            end else begin
                y_d = y_q - x_q;
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // Operand registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q <= {W{1'b0}};
            y_q <= {W{1'b0}};
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/gcd_rr_sched.sv
// Round-robin arbiter and IDLE/RUN/DONE control sharing one gcd_core among NREQ requesters.
// Define GCD_SCHED_PERF_EN to add saturating perf_jobs / perf_cycles counters.
module gcd_rr_sched
    import gcd_pkg::*;
#(
    parameter int NREQ = GCD_NREQ,
    parameter int W    = GCD_W
) (
    input  logic          clk,
    input  logic          rst,
    gcd_rr_sched_if.slave bus
`ifdef GCD_SCHED_PERF_EN
    ,
    output logic [31:0]   perf_jobs,
    output logic [31:0]   perf_cycles
`endif
);

    localparam int IDW = gcd_id_w(NREQ);

    gcd_state_e     state_q;
    logic [IDW-1:0] last_grant_q;
    logic [IDW-1:0] res_id_q;
    logic [W-1:0]   res_gcd_q;
    logic           res_valid_q;
    logic           busy_q;

    logic [NREQ-1:0] grant_s;
    logic [IDW-1:0]  win_s;
    logic            found_s;
    logic            req_hs_s;
    logic            core_done_s;
    logic [W-1:0]    core_result_s;
    logic [W-1:0]    sel_x_s;
    logic [W-1:0]    sel_y_s;
    int              idx_s;

    // Search starts just after the last served requester and wraps around.
    always_comb begin
        grant_s = {NREQ{1'b0}};
        win_s   = {IDW{1'b0}};
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_s = (int'(last_grant_q) + k) % NREQ;
            if (!found_s && bus.req_valid[idx_s]) begin
                found_s = 1'b1;
                win_s   = IDW'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
        if (found_s && (state_q == IDLE) && rst) begin
            grant_s[win_s] = 1'b1;
        end else begin
            grant_s = {NREQ{1'b0}};
        end
    end

    assign req_hs_s = |grant_s;
    assign sel_x_s  = bus.req_x[win_s*W +: W];
    assign sel_y_s  = bus.req_y[win_s*W +: W];

    gcd_core #(.W(W)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (req_hs_s),
        .x_in   (sel_x_s),
        .y_in   (sel_y_s),
        .step   (state_q == RUN),
        .done   (core_done_s),
        .result (core_result_s)
    );

    // Control FSM with registered result/busy outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            res_id_q     <= {IDW{1'b0}};
            res_gcd_q    <= {W{1'b0}};
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_hs_s) begin
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                        res_id_q <= win_s;
                    end
                end
                RUN: begin
                    if (core_done_s) begin
                        state_q     <= DONE;
                        res_valid_q <= 1'b1;
                        res_gcd_q   <= core_result_s;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state_q      <= IDLE;
                        res_valid_q  <= 1'b0;
                        busy_q       <= 1'b0;
                        last_grant_q <= res_id_q;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = grant_s;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_gcd   = res_gcd_q;
    assign bus.busy      = busy_q;

`ifdef GCD_SCHED_PERF_EN
    logic [31:0] perf_jobs_q;
    logic [31:0] perf_cycles_q;

    // Saturating job and RUN-cycle counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_jobs_q   <= 32'd0;
            perf_cycles_q <= 32'd0;
        end else begin
            if ((state_q == DONE) && bus.res_ready && (perf_jobs_q != 32'hFFFF_FFFF)) begin
                perf_jobs_q <= perf_jobs_q + 32'd1;
            end
            if ((state_q == RUN) && (perf_cycles_q != 32'hFFFF_FFFF)) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
        end
    end

    assign perf_jobs   = perf_jobs_q;
    assign perf_cycles = perf_cycles_q;
`endif

endmodule

// File: tb/tb_gcd_rr_sched.sv
// Directed self-checking bench for gcd_rr_sched (NREQ=4, W=16).
module tb_gcd_rr_sched;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gcd_rr_sched_if #(.NREQ(4), .W(16)) bus ();

`ifdef GCD_SCHED_PERF_EN
    logic [31:0] perf_jobs;
    logic [31:0] perf_cycles;
`endif

    gcd_rr_sched #(.NREQ(4), .W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef GCD_SCHED_PERF_EN
        ,
        .perf_jobs   (perf_jobs),
        .perf_cycles (perf_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for res_valid, returning clocks elapsed (0 = expired bound).
    task automatic wait_res(output int lat);
        lat = 0;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (bus.res_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_job(input int id, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] exp_g, input int exp_lat);
        int lat;
        bus.req_valid = 4'(1 << id);
        bus.req_x = 64'd0;
        bus.req_y = 64'd0;
        bus.req_x[id*16 +: 16] = x;
        bus.req_y[id*16 +: 16] = y;
        #1;
        chk("job_grant", 32'(bus.req_ready), 32'(1 << id));
        tick();
        bus.req_valid = 4'd0;
        bus.req_x = {64{1'b1}};
        bus.req_y = {64{1'b1}};
        wait_res(lat);
        chk("job_latency", 32'(lat), 32'(exp_lat));
        chk("job_id", 32'(bus.res_id), 32'(id));
        chk("job_gcd", 32'(bus.res_gcd), 32'(exp_g));
        chk("job_busy", 32'(bus.busy), 32'd1);
        chk("job_ready_zero", 32'(bus.req_ready), 32'd0);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk("job_res_dropped", 32'(bus.res_valid), 32'd0);
        chk("job_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int hits;
        bus.req_valid = 4'hF;
        bus.req_x     = 64'd0;
        bus.req_y     = 64'd0;
        bus.res_ready = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_res_id", 32'(bus.res_id), 32'd0);
        chk("rst_res_gcd", 32'(bus.res_gcd), 32'd0);
        rst = 1'b1;
        bus.req_valid = 4'd0;
        tick();

        // (12,8): 12-8, 8-4, then equal -> 4 after 3 clocks
        run_job(2, 16'd12, 16'd8, 16'd4, 3);
        run_job(0, 16'd0, 16'd35, 16'd0, 1);
        run_job(3, 16'd35, 16'd35, 16'd35, 1);
`ifdef GCD_SCHED_PERF_EN
        chk("perf_jobs", perf_jobs, 32'd3);
        chk("perf_cycles", perf_cycles, 32'd5);
`endif

        // Fairness: last grant was 3, so order is 0,1,2,3,0
        for (int i = 0; i < 4; i++) begin
            bus.req_x[i*16 +: 16] = 16'((i + 1) * 6);
            bus.req_y[i*16 +: 16] = 16'((i + 1) * 4);
        end
        bus.req_valid = 4'hF;
        bus.res_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            chk("fair_grant", 32'(bus.req_ready), 32'(1 << (g % 4)));
            tick();
            wait_res(lat);
            chk("fair_latency", 32'(lat), 32'd3);
            chk("fair_id", 32'(bus.res_id), 32'(g % 4));
            chk("fair_gcd", 32'(bus.res_gcd), 32'(((g % 4) + 1) * 2));
            tick();
        end
        bus.req_valid = 4'd0;
        bus.res_ready = 1'b0;
        tick();

        // Backpressure: (9,6) from requester 1 while requester 0 waits
        bus.req_x = 64'd0;
        bus.req_y = 64'd0;
        bus.req_x[16 +: 16] = 16'd9;
        bus.req_y[16 +: 16] = 16'd6;
        bus.req_valid = 4'b0010;
        #1;
        chk("bp_grant", 32'(bus.req_ready), 32'd2);
        tick();
        bus.req_valid = 4'b0001;
        wait_res(lat);
        chk("bp_latency", 32'(lat), 32'd3);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_valid_hold", 32'(bus.res_valid), 32'd1);
            chk("bp_id_hold", 32'(bus.res_id), 32'd1);
            chk("bp_gcd_hold", 32'(bus.res_gcd), 32'd3);
            chk("bp_no_grant", 32'(bus.req_ready), 32'd0);
        end
        bus.res_ready = 1'b1;
        #1;
        chk("bp_no_same_cycle_grant", 32'(bus.req_ready), 32'd0);
        tick();
        bus.res_ready = 1'b0;
        chk("bp_regrant", 32'(bus.req_ready), 32'd1);
        chk("bp_res_dropped", 32'(bus.res_valid), 32'd0);
        bus.req_valid = 4'd0;
        tick();

        // Reset during RUN cycle 10 of (65535,1)
        bus.req_x[16 +: 16] = 16'd65535;
        bus.req_y[16 +: 16] = 16'd1;
        bus.req_valid = 4'b0010;
        #1;
        chk("abort_grant", 32'(bus.req_ready), 32'd2);
        tick();
        bus.req_valid = 4'd0;
        for (int c = 0; c < 9; c++) tick();
        chk("abort_busy_before", 32'(bus.busy), 32'd1);
        chk("abort_valid_before", 32'(bus.res_valid), 32'd0);
        rst = 1'b0;
        bus.req_valid = 4'b0101;
        #1;
        chk("abort_ready_in_rst", 32'(bus.req_ready), 32'd0);
        tick();
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_valid", 32'(bus.res_valid), 32'd0);
        chk("abort_id", 32'(bus.res_id), 32'd0);
        chk("abort_gcd", 32'(bus.res_gcd), 32'd0);
`ifdef GCD_SCHED_PERF_EN
        chk("perf_jobs_clr", perf_jobs, 32'd0);
        chk("perf_cycles_clr", perf_cycles, 32'd0);
`endif
        rst = 1'b1;
        #1;
        chk("abort_next_grant", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 4'd0;
        hits = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.res_valid !== 1'b0) hits++;
        end
        chk("abort_no_replay", 32'(hits), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcd_rr_sched.md
GCD_RR_SCHED -- requirements
Module: gcd_rr_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the GCD datapath (2..8).
REQ-002 Parameter W, default 16: operand and result width in bits.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst  input  1  synchronous, active-low reset.
REQ-005 Port req_valid  input  NREQ  per-requester job-request flag.
REQ-006 Port req_x  input  NREQ*W  packed x operands, requester i in bits [i*W +: W].
REQ-007 Port req_y  input  NREQ*W  packed y operands, same packing.
REQ-008 Port req_ready  output  NREQ  one-hot grant; the job is accepted on a clock where req_valid[i] and req_ready[i] are both 1.
REQ-009 Port res_valid  output  1  result available.
REQ-010 Port res_id  output  clog2(NREQ)  index of the requester that owns the result.
REQ-011 Port res_gcd  output  W  GCD result.
REQ-012 Port res_ready  input  1  consumer accepts the result on a clock where res_valid and res_ready are both 1.
REQ-013 Port busy  output  1  1 in every state except IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 IDLE: req_ready SHALL be combinational and one-hot on the round-robin winner among the asserted req_valid bits, and all-zero when no request is asserted.
REQ-016 Round-robin order: the search starts at (last_grant+1) mod NREQ and wraps.
REQ-017 last_grant SHALL update only on the res_valid/res_ready handshake.
REQ-018 On the request handshake, operands SHALL be latched into the core, the winner index latched as res_id, and the FSM SHALL go IDLE->RUN.
REQ-019 req_ready SHALL be all-zero in RUN and DONE.
REQ-020 RUN SHALL perform exactly one evaluation per clock on the latched (x,y), checked in this order:
- if x==0 or y==0: result=0, go to DONE;
- else if x==y: result=x, go to DONE;
- else if x>y: x<=x-y;
- else: y<=y-x.
REQ-021 Latency: res_valid SHALL rise S+1 clocks after the request-handshake edge, where S is the number of subtractions.
REQ-022 DONE: res_valid=1, and res_id and res_gcd SHALL be held stable until res_ready.
REQ-023 On the result handshake the FSM SHALL go DONE->IDLE, and a new grant is possible on the following clock (no same-cycle re-grant).
REQ-024 Arithmetic SHALL be unsigned W-bit, with no wrap possible because the larger operand is always the minuend.
REQ-025 A change on req_x/req_y after acceptance SHALL have no effect on the job in flight.

Reset
REQ-026 When rst==0 at a clock edge, the block SHALL set: FSM=IDLE, res_valid=0, res_id=0, res_gcd=0, busy=0, and last_grant=NREQ-1, so requester 0 has top priority.
REQ-027 A reset in RUN or DONE SHALL abort the job with no result delivered; it is not replayed.
REQ-028 req_ready SHALL be all-zero while rst==0.

Configuration
REQ-029 Macro GCD_SCHED_PERF_EN, when defined, SHALL add these outputs:
- perf_jobs (32-bit): counts result handshakes;
- perf_cycles (32-bit): counts clocks spent in RUN;
- both saturate at all-ones and clear on reset.
REQ-030 When GCD_SCHED_PERF_EN is undefined, those ports and counters SHALL be absent and all other behaviour identical.

Structure
REQ-031 Package gcd_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE), the default W and NREQ constants, and the id-width function.
REQ-032 The subtractive datapath SHALL be a sub-module gcd_core with ports:
- clk, rst;
- load, x_in, y_in;
- step;
- done, result.
REQ-033 The arbitration and FSM logic SHALL reside in gcd_rr_sched.

Verification
REQ-034 Single job: requester 2 sends (12,8) -> req_ready=4'b0100, res_valid 3 clocks after the handshake, res_id=2, res_gcd=4.
REQ-035 Zero operand: (0,35) -> res_gcd=0 at 1 clock after the handshake; (35,35) -> res_gcd=35 at 1 clock.
REQ-036 Fairness: all four req_valid held high with res_ready=1 -> grants in order 0,1,2,3,0, and res_id follows the same order.
REQ-037 Backpressure: res_ready=0 for 5 clocks in DONE -> res_valid, res_id and res_gcd stable throughout; no new grant until one clock after res_ready=1.
REQ-038 Reset mid-RUN: (65535,1) accepted, rst=0 at RUN cycle 10 -> no res_valid, busy=0, and the next grant goes to requester 0.
REQ-039 GCD_SCHED_PERF_EN defined: run the REQ-034 and REQ-035 jobs -> perf_jobs=3, perf_cycles=5.
